// File: rtl/mips_loader_pkg.sv
// Shared types and helpers for the serial instruction-memory loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling, one-cycle byte strobe.
module uart_rx_core
  import mips_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign data = shreg;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          // A line already back high at half a bit is a glitch, not a start bit.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            byte_valid <= 1'b1;
            frame_err  <= ~rx_sync;
            state      <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mips_uart_loader.sv
// Frame parser that streams UART bytes into instruction memory while holding the CPU.
module mips_uart_loader
  import mips_loader_pkg::*;
#(
  parameter int         CLK_HZ       = 100000000,
  parameter int         BAUD         = 115200,
  parameter int         MEM_BYTES    = 100,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx,
  output logic       mem_we,
  output logic [6:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
  localparam int TMAX = TIMEOUT_BITS * CPB;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TMAX - 1);
  localparam logic [7:0]    LEN_MAX = 8'(MEM_BYTES);

  logic [7:0]    rx_data;
  logic          byte_valid;
  logic          frame_err;
  ld_state_t     state;
  logic [6:0]    len;
  logic [6:0]    addr;
  logic [7:0]    acc;
  logic [TW-1:0] tcnt;
  logic          active;
  logic          expired;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk_in     (clk_in),
    .reset      (reset),
    .rx         (rx),
    .data       (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign active  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  // A byte arriving in the expiry cycle takes priority because the FSM checks byte_valid first.
  assign expired = active && (tcnt == T_LAST);

  always_ff @(posedge clk_in) begin
    if (reset || byte_valid || !active) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len       <= '0;
      addr      <= '0;
      acc       <= '0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (byte_valid && !frame_err && rx_data == SYNC_BYTE) begin
            cpu_hold <= 1'b1;
            load_err <= 1'b0;
            state    <= S_LEN;
          end
        end
        S_LEN: begin
          if (byte_valid) begin
            if (frame_err || rx_data == 8'd0 || rx_data > LEN_MAX) begin
              load_err <= 1'b1;
              state    <= S_ERR;
            end else begin
              len   <= rx_data[6:0];
              addr  <= '0;
              acc   <= '0;
              state <= S_DATA;
            end
          end else if (expired) begin
            load_err <= 1'b1;
            state    <= S_ERR;
          end
        end
        S_DATA: begin
          if (byte_valid) begin
            if (frame_err) begin
              load_err <= 1'b1;
              state    <= S_ERR;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= rx_data;
              acc       <= acc ^ rx_data;
              addr      <= addr + 7'd1;
              if (addr + 7'd1 == len) state <= S_CSUM;
            end
          end else if (expired) begin
            load_err <= 1'b1;
            state    <= S_ERR;
          end
        end
        S_CSUM: begin
          // Outputs change on entry to DONE/ERR so they appear one cycle after the byte.
          if (byte_valid) begin
            if (frame_err || rx_data != acc) begin
              load_err <= 1'b1;
              state    <= S_ERR;
            end else begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
              state     <= S_DONE;
            end
          end else if (expired) begin
            load_err <= 1'b1;
            state    <= S_ERR;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_uart_loader.sv
// Directed and randomized frames checked against a frame-level reference model.
module tb_mips_uart_loader;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       rx     = 1'b1;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  logic [6:0] wa[$];
  logic [7:0] wd[$];
  int         done_cnt = 0;
  logic [7:0] fdata[0:127];

  always #5 clk_in = ~clk_in;

  mips_uart_loader #(
    .CLK_HZ(16), .BAUD(1), .MEM_BYTES(100), .TIMEOUT_BITS(20), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always @(negedge clk_in) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stop;
    tick(16);
    if (!stop) begin
      rx = 1'b1;
      tick(16);
    end
    rx = 1'b1;
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  function automatic logic [7:0] xor_n(input int n);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < n; i++) r ^= fdata[i];
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] len, input int n, input logic [7:0] csum);
    send_byte(8'hA5, 1'b1);
    send_byte(len, 1'b1);
    for (int i = 0; i < n; i++) send_byte(fdata[i], 1'b1);
    send_byte(csum, 1'b1);
  endtask

  task automatic check_frame(input string tag, input int n_exp, input int done_exp,
                             input int err_exp, input int hold_exp);
    tick(20);
    check({tag, "_nwr"}, wa.size(), n_exp);
    for (int i = 0; i < n_exp && i < wa.size(); i++) begin
      check({tag, "_addr"}, int'(wa[i]), i);
      check({tag, "_data"}, int'(wd[i]), int'(fdata[i]));
    end
    check({tag, "_done"}, done_cnt, done_exp);
    check({tag, "_err"}, int'(load_err), err_exp);
    check({tag, "_hold"}, int'(cpu_hold), hold_exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, int'(mem_we), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
    check({tag, "_wdata"}, int'(mem_wdata), 0);
    check({tag, "_hold"}, int'(cpu_hold), 0);
    check({tag, "_done"}, int'(load_done), 0);
    check({tag, "_err"}, int'(load_err), 0);
  endtask

  initial begin
    int         n;
    int         len;
    int         exp_n;
    logic       good;
    logic [7:0] csum;

    tick(5);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(5);

    // Good frame; checksum is the XOR of the data bytes.
    clear_mon();
    fdata[0] = 8'h20; fdata[1] = 8'h08; fdata[2] = 8'h00; fdata[3] = 8'h05;
    send_byte(8'hA5, 1'b1);
    check("t1_hold_sync", int'(cpu_hold), 1);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(fdata[i], 1'b1);
    check("t1_hold_mid", int'(cpu_hold), 1);
    send_byte(xor_n(4), 1'b1);
    check_frame("t1", 4, 1, 0, 0);

    // Bad checksum, then recovery with a good frame.
    clear_mon();
    send_frame(8'h04, 4, 8'h2E);
    check_frame("t2_bad", 4, 0, 1, 1);
    clear_mon();
    send_frame(8'h04, 4, xor_n(4));
    check_frame("t2_good", 4, 1, 0, 0);

    // Illegal lengths at both ends of the range.
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    check_frame("t3_len0", 0, 0, 1, 1);
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'd101, 1'b1);
    check_frame("t3_len101", 0, 0, 1, 1);
    clear_mon();
    send_byte(8'h33, 1'b1);
    fdata[0] = 8'h7E;
    send_frame(8'h01, 1, 8'h7E);
    check_frame("t3_recover", 1, 1, 0, 0);

    // Timeout after 20 bit-times of silence mid-frame.
    clear_mon();
    fdata[0] = 8'h11;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(fdata[0], 1'b1);
    tick(300);
    check("t4_err_early", int'(load_err), 0);
    tick(30);
    check("t4_err_late", int'(load_err), 1);
    check_frame("t4", 1, 0, 1, 1);

    // Short glitch is rejected; a bad stop bit aborts the frame.
    clear_mon();
    fdata[0] = 8'hAA;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(fdata[0], 1'b1);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("t5_glitch_nwr", wa.size(), 1);
    check("t5_glitch_err", int'(load_err), 0);
    send_byte(8'h5C, 1'b0);
    check_frame("t5", 1, 0, 1, 1);

    // Reset in the middle of the data phase.
    clear_mon();
    fdata[0] = 8'h01; fdata[1] = 8'h02;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(fdata[0], 1'b1);
    send_byte(fdata[1], 1'b1);
    check("t6_pre_nwr", wa.size(), 2);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("t6_rst");
    reset = 1'b0;
    tick(5);
    clear_mon();
    for (int i = 0; i < 3; i++) fdata[i] = 8'($urandom);
    send_frame(8'h03, 3, xor_n(3));
    check_frame("t6_reload", 3, 1, 0, 0);

    // Randomized frames against the frame-level model.
    for (int k = 0; k < 8; k++) begin
      clear_mon();
      if (k == 4) begin
        len = $urandom_range(101, 255);
        send_byte(8'hA5, 1'b1);
        send_byte(8'(len), 1'b1);
        check_frame("rnd_badlen", 0, 0, 1, 1);
      end else begin
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) fdata[i] = 8'($urandom);
        csum = xor_n(n);
        if ($urandom_range(0, 2) == 0) csum ^= 8'(1 << $urandom_range(0, 7));
        good  = (csum == xor_n(n));
        exp_n = n;
        send_frame(8'(n), n, csum);
        check_frame("rnd", exp_n, good ? 1 : 0, good ? 0 : 1, good ? 0 : 1);
      end
    end

    // Maximum legal length.
    clear_mon();
    for (int i = 0; i < 100; i++) fdata[i] = 8'($urandom);
    send_frame(8'd100, 100, xor_n(100));
    check_frame("max_len", 100, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
